booth_seq_mult: RTL and testbench
=================================

# booth_seq_mult

Parametrised, iterative radix-4 Booth multiplier. It is the sequential successor to the team's 4-bit combinational Booth array. It retires one Booth digit per clock from a W-bit multiplier x against a W-bit multiplicand y, in signed or unsigned mode selected per operation. It sits behind a valid/ready request port and in front of a valid/ready result port, so it can be dropped into the datapath where area matters more than throughput.

## Interface
- W, 8: operand width. Must be even and ≥ 4. Product width is 2W.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_x  input  W  multiplier (Booth-recoded).
- in_y  input  W  multiplicand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_p  output  2W  product.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. A request is accepted when in_valid & in_ready. On accept:
  - latch x, y and the mode bit;
  - clear the accumulator and the digit counter k;
  - go to RUN.
- Digit count N:
  - signed: N = W/2;
  - unsigned: N = W/2+1, with x zero-extended by 2 bits.
- RUN, step k (0..N-1):
  - Triplet is {x[2k+1], x[2k], x[2k-1]}, with x[-1]=0.
  - Encoder gives single, double, neg and selects digit d_k ∈ {-2,-1,0,+1,+2}.
  - Y = y sign-extended (signed) or zero-extended (unsigned) to W+2 bits.
  - Accumulate d_k·Y·4^k into a 2W+2-bit register. Negation is one's complement of the selected multiple plus carry-in = neg.
  - After step N-1, go to DONE.
- DONE: out_valid=1 and out_p = accumulator[2W-1:0]. out_p is stable while out_valid & !out_ready. On out_ready, go to IDLE.
- Unsigned case: (2^W-1)² fits in 2W bits, so truncation is exact. Same for signed (-2^(W-1))².
- in_signed, in_x and in_y are sampled only at accept. Changes at any other time are ignored.
- in_valid while not IDLE is not accepted. The requester holds it.
- No overlap: the next accept happens no earlier than the cycle after the out handshake.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_p=0, busy=0, accumulator=0, k=0.
- Accept at edge t0. RUN occupies N edges. out_valid rises after edge t0+N and is observable in cycle t0+N+1.
  - W=8 signed: result 5 cycles after accept.
  - W=8 unsigned: result 6 cycles after accept.
- in_ready is combinational from state (IDLE only). There is no in→out combinational path.
- Back-to-back: with out_ready held high, throughput is one result per N+2 cycles.
- Reset asserted mid-RUN or in DONE:
  - abort immediately and asynchronously, with all outputs at their reset values;
  - the pending result is discarded;
  - after release, the first edge with in_valid accepts a new request.

## Structure
- Package booth_pkg:
  - state enum (IDLE, RUN, DONE);
  - digit-select encoding;
  - function n_digits(W, signed) returning N.
- Sub-module booth_digit_encoder: combinational. Takes a 3-bit triplet and produces single, double, neg. This is the only shared logic.
- The datapath adder (W+3 bits) is inferred in the top module.

## Test plan
- W=8, signed, x=7, y=-3 -> out_p=16'hFFEB, out_valid exactly 5 cycles after accept.
- W=8, signed, x=-128, y=-128 -> out_p=16'h4000. Then x=-128, y=127 -> 16'hC080.
- W=8, unsigned, x=255, y=255 -> out_p=16'hFE01 after 6 cycles. Same operands signed -> 16'h0001.
- out_ready held low 10 cycles in DONE:
  - out_p stays constant and in_ready stays 0;
  - a new in_valid with x=3, y=3 is not accepted until the cycle after out_ready.
- Assert rst 2 cycles into RUN (x=5, y=9):
  - out_valid=0 and out_p=0 immediately;
  - the next request x=2, y=3 returns 6 with normal latency.
- Random: 10k operations at W=8 and W=16, mixed modes and random backpressure, checked against a behavioural product.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit select: |d| = 1 (single) or 2 (twice), sign from neg.
  typedef struct packed {
    logic neg;
    logic twice;
    logic single;
  } booth_sel_t;

  // Booth digits retired for a W-bit operand; unsigned needs one extra digit.
  function automatic int unsigned n_digits(input int unsigned w, input logic sgn);
    return sgn ? (w / 2) : (w / 2 + 1);
  endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth recoder: one multiplier bit triplet to a digit select.
module booth_digit_encoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output booth_sel_t sel_c
);

  // Triplet 111 maps to a plain zero, so neg is suppressed there.
  always_comb begin
    sel_c        = '0;
    sel_c.single = triplet[1] ^ triplet[0];
    sel_c.twice  = (triplet == 3'b100) | (triplet == 3'b011);
    sel_c.neg    = triplet[2] & ~(triplet[1] & triplet[0]);
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier: one digit per clock, valid/ready on both sides.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             busy
);

  localparam int unsigned XW = W + 3;
  localparam int unsigned YW = W + 2;
  localparam int unsigned SW = W + 3;
  localparam int unsigned AW = 2 * W + 2;
  localparam int unsigned KW = $clog2(W / 2 + 2);
  // The extra unsigned digit lands exactly on the final alignment, so it adds without shifting.
  localparam logic [KW-1:0] K_NOSHIFT = KW'(W / 2);

  state_t          state_q, state_d;
  logic [XW-1:0]   xs_q;
  logic [YW-1:0]   y_q;
  logic            sgn_q;
  logic [AW-1:0]   acc_q;
  logic [KW-1:0]   k_q;

  booth_sel_t      sel;
  logic            accept;
  logic            last;
  logic [SW-1:0]   sel_mag;
  logic [SW-1:0]   addend;
  logic [SW-1:0]   sum;
  logic [AW-1:0]   acc_step;

  booth_digit_encoder u_enc (
    .triplet (xs_q[2:0]),
    .sel_c   (sel)
  );

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign last     = (k_q == KW'(n_digits(W, sgn_q) - 1));
  assign out_p    = acc_q[2*W-1:0];

  // The accumulator high part carries the running sum scaled so each digit adds at a fixed position.
  always_comb begin
    sel_mag = '0;
    if (sel.twice) begin
      sel_mag = {y_q, 1'b0};
    end else if (sel.single) begin
      sel_mag = {y_q[YW-1], y_q};
    end
    addend   = sel.neg ? ~sel_mag : sel_mag;
    sum      = {acc_q[AW-1], acc_q[AW-1:W]} + addend + SW'(sel.neg);
    acc_step = (k_q != K_NOSHIFT) ? {sum[SW-1], sum, acc_q[W-1:2]}
                                  : {sum[SW-2:0], acc_q[W-1:0]};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Operand capture at accept, then one Booth digit retired per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q  <= '0;
      y_q   <= '0;
      sgn_q <= 1'b0;
      acc_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      xs_q  <= in_signed ? {{2{in_x[W-1]}}, in_x, 1'b0} : {2'b00, in_x, 1'b0};
      y_q   <= in_signed ? {{2{in_y[W-1]}}, in_y} : {2'b00, in_y};
      sgn_q <= in_signed;
      acc_q <= '0;
      k_q   <= '0;
    end else if (state_q == RUN) begin
      xs_q  <= {2'b00, xs_q[XW-1:2]};
      acc_q <= acc_step;
      k_q   <= k_q + KW'(1);
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: directed table, hand-written corner sequences, randomized W=8/W=16 runs.
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid8 = 1'b0, in_signed8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  in_x8 = '0, in_y8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] out_p8;

  logic        in_valid16 = 1'b0, in_signed16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] in_x16 = '0, in_y16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] out_p16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_mult #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_signed(in_signed8), .in_x(in_x8), .in_y(in_y8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_p(out_p8), .busy(busy8)
  );

  booth_seq_mult #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_signed(in_signed16), .in_x(in_x16), .in_y(in_y16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_p(out_p16), .busy(busy16)
  );

  typedef struct {
    bit          sgn;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference product: plain integer arithmetic truncated to 2w bits.
  function automatic logic [63:0] model(input int w, input bit sgn,
                                        input longint unsigned x, input longint unsigned y);
    longint a, b, p;
    longint unsigned mask;
    mask = (64'(1) << (2 * w)) - 64'(1);
    a = longint'(x);
    b = longint'(y);
    if (sgn && x[w-1]) a = a - longint'(64'(1) << w);
    if (sgn && y[w-1]) b = b - longint'(64'(1) << w);
    p = a * b;
    return longint'(p) & mask;
  endfunction

  // Edges from accept to out_valid: one per Booth digit.
  function automatic int exp_lat(input int w, input bit sgn);
    return sgn ? (w / 2) : (w / 2 + 1);
  endfunction

  task automatic wait8(output logic [15:0] p, output int lat);
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    p = out_p8;
  endtask

  task automatic wait16(output logic [31:0] p, output int lat);
    lat = 0;
    while (out_valid16 !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    p = out_p16;
  endtask

  task automatic op8(input bit sgn, input logic [7:0] x, input logic [7:0] y, input int bp,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; in_signed8 = sgn; in_x8 = x; in_y8 = y;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; in_x8 = 8'($urandom); in_y8 = 8'($urandom); in_signed8 = 1'($urandom);
    wait8(p, lat);
    repeat (bp) @(negedge clk);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic op16(input bit sgn, input logic [15:0] x, input logic [15:0] y, input int bp,
                      output logic [31:0] p, output int lat);
    @(negedge clk);
    in_valid16 = 1'b1; in_signed16 = sgn; in_x16 = x; in_y16 = y;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0; in_x16 = 16'($urandom); in_y16 = 16'($urandom); in_signed16 = 1'($urandom);
    wait16(p, lat);
    repeat (bp) @(negedge clk);
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  task automatic rand8(input int n);
    bit sgn; logic [7:0] x, y; logic [15:0] p; int lat;
    for (int i = 0; i < n; i++) begin
      sgn = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      op8(sgn, x, y, int'($urandom_range(0, 2)), p, lat);
      check("rnd8_p", 64'(p), model(8, sgn, 64'(x), 64'(y)));
      check("rnd8_lat", 64'(lat), 64'(exp_lat(8, sgn)));
    end
  endtask

  task automatic rand16(input int n);
    bit sgn; logic [15:0] x, y; logic [31:0] p; int lat;
    for (int i = 0; i < n; i++) begin
      sgn = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      op16(sgn, x, y, int'($urandom_range(0, 2)), p, lat);
      check("rnd16_p", 64'(p), model(16, sgn, 64'(x), 64'(y)));
      check("rnd16_lat", 64'(lat), 64'(exp_lat(16, sgn)));
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] p;
    int lat;

    tbl[0]  = '{1'b1, 8'h07, 8'hFD, 16'hFFEB, 4};
    tbl[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 4};
    tbl[2]  = '{1'b1, 8'h80, 8'h7F, 16'hC080, 4};
    tbl[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5};
    tbl[4]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 4};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 16'h0000, 5};
    tbl[6]  = '{1'b0, 8'h01, 8'hFF, 16'h00FF, 5};
    tbl[7]  = '{1'b1, 8'h7F, 8'h80, 16'hC080, 4};
    tbl[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 5};
    tbl[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 4};
    tbl[10] = '{1'b0, 8'hC8, 8'h64, 16'h4E20, 5};
    tbl[11] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, 4};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready8", 64'(in_ready8), 64'(1));
    check("rst_out_valid8", 64'(out_valid8), 64'(0));
    check("rst_out_p8", 64'(out_p8), 64'(0));
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_in_ready16", 64'(in_ready16), 64'(1));
    check("rst_out_valid16", 64'(out_valid16), 64'(0));
    check("rst_out_p16", 64'(out_p16), 64'(0));
    check("rst_busy16", 64'(busy16), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      op8(tbl[i].sgn, tbl[i].x, tbl[i].y, 0, p, lat);
      check($sformatf("tbl%0d_p", i), 64'(p), 64'(tbl[i].p));
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
    end

    // Backpressure: result held 10 cycles while a new request waits.
    @(negedge clk);
    in_valid8 = 1'b1; in_signed8 = 1'b1; in_x8 = 8'd100; in_y8 = 8'hF9;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    wait8(p, lat);
    check("bp_first_p", 64'(p), 64'(16'hFD44));
    in_valid8 = 1'b1; in_signed8 = 1'b0; in_x8 = 8'd3; in_y8 = 8'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_p", 64'(out_p8), 64'(16'hFD44));
      check("bp_hold_valid", 64'(out_valid8), 64'(1));
      check("bp_in_ready", 64'(in_ready8), 64'(0));
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("bp_idle_ready", 64'(in_ready8), 64'(1));
    check("bp_idle_busy", 64'(busy8), 64'(0));
    check("bp_idle_valid", 64'(out_valid8), 64'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("bp_accept_busy", 64'(busy8), 64'(1));
    wait8(p, lat);
    check("bp_second_p", 64'(p), 64'(16'h0009));
    check("bp_second_lat", 64'(lat), 64'(5));
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;

    // Reset two digits into a run discards the operation at once.
    @(negedge clk);
    in_valid8 = 1'b1; in_signed8 = 1'b1; in_x8 = 8'd5; in_y8 = 8'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid8), 64'(0));
    check("abort_out_p", 64'(out_p8), 64'(0));
    check("abort_busy", 64'(busy8), 64'(0));
    check("abort_in_ready", 64'(in_ready8), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    op8(1'b1, 8'd2, 8'd3, 0, p, lat);
    check("post_abort_p", 64'(p), 64'(16'h0006));
    check("post_abort_lat", 64'(lat), 64'(4));

    fork
      rand8(5000);
      rand16(5000);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
